// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module : serial_adder_pkg
// Brief  : Shared FSM state encoding and sizing helpers for serial_adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter must hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// Module : full_adder_cell
// Brief  : One-bit combinational full adder, used as a ripple-chain element.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic s
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module : serial_adder
// Brief  : Multi-cycle adder, DIGIT bits per clock through a ripple chain of
//          full_adder_cell instances; signed overflow output enabled by
//          defining SERIAL_ADD_OVF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: illegal WIDTH/DIGIT combination");
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_step;
    logic [WIDTH-1:0]       r_opa;
    logic [WIDTH-1:0]       r_opb;
    logic [WIDTH-1:0]       r_acc;
    logic                   r_carry;
    logic [WIDTH-1:0]       r_s;
    logic                   r_cout;
    logic [DIGIT:0]         w_c;
    logic [DIGIT-1:0]       w_sum;
    logic [WIDTH+DIGIT-1:0] w_acc_cat;
    logic [WIDTH-1:0]       w_acc_next;
    logic                   w_last;

    // Ripple chain over the current low digit; w_c[DIGIT-1] is the carry into
    // the top cell, which on the final step is the carry into bit WIDTH-1.
    assign w_c[0] = r_carry;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder_cell u_fa (
            .x    (r_opa[i]),
            .y    (r_opb[i]),
            .cin  (w_c[i]),
            .cout (w_c[i+1]),
            .s    (w_sum[i])
        );
    end

    // New digit enters from the MSB side so the LSB digit ends at bit 0.
    assign w_acc_cat  = {w_sum, r_acc};
    assign w_acc_next = w_acc_cat[WIDTH+DIGIT-1:DIGIT];
    assign w_last     = (r_step == LAST_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step  <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opa   <= x;
                        r_opb   <= y;
                        r_carry <= cin;
                        r_step  <= '0;
                    end
                end
                ST_RUN: begin
                    r_opa   <= r_opa >> DIGIT;
                    r_opb   <= r_opb >> DIGIT;
                    r_carry <= w_c[DIGIT];
                    r_acc   <= w_acc_next;
                    r_step  <= r_step + CW'(1);
                    // Visible result only changes when the new one completes.
                    if (w_last) begin
                        r_s    <= w_acc_next;
                        r_cout <= w_c[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_RUN && w_last) begin
            r_ovf <= w_c[DIGIT-1] ^ w_c[DIGIT];
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign s    = r_s;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module : tb_serial_adder
// Brief  : Scoreboard bench for serial_adder with randomized operands.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int WIDTH = 8;
    parameter  int DIGIT = 1;
    localparam int STEPS = WIDTH / DIGIT;
    localparam int BOUND = 4 * STEPS + 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    serial_adder #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic             ovf;
        logic             cout;
        logic [WIDTH-1:0] s;
    } res_t;

    res_t exp_q[$];
    res_t last = '0;
    res_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Reference: plain integer addition, signed overflow from operand/result signs.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c);
        res_t             r;
        logic [WIDTH:0]   full;
        full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        r.s    = full[WIDTH-1:0];
        r.cout = full[WIDTH];
`ifdef SERIAL_ADD_OVF_EN
        r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
`else
        r.ovf  = 1'b0;
`endif
        return r;
    endfunction

    // Monitor: pops on done, otherwise requires the previous result to hold.
    always @(negedge clk) begin
        if (rst) begin
            last = '0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum",  {56'd0, s}, {56'd0, mon_e.s});
                check("cout", {63'd0, cout}, {63'd0, mon_e.cout});
`ifdef SERIAL_ADD_OVF_EN
                check("ovf",  {63'd0, ovf}, {63'd0, mon_e.ovf});
`endif
                last = mon_e;
            end
        end else begin
            check("hold_result", {55'd0, ovf, cout, s}, {55'd0, last});
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((busy || done) && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        if (k >= BOUND) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_done(output int cycles, output int busy_cnt);
        bit got;
        got      = 1'b0;
        cycles   = 0;
        busy_cnt = 0;
        while (!got && cycles < BOUND) begin
            @(negedge clk);
            cycles++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input bit scramble);
        int cyc, bc;
        wait_idle();
        x = a; y = b; cin = c; start = 1'b1;
        exp_q.push_back(model(a, b, c));
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scramble) begin
            x   = WIDTH'($urandom);
            y   = WIDTH'($urandom);
            cin = 1'($urandom);
        end
        wait_done(cyc, bc);
        check("done_latency", 64'(cyc), 64'(STEPS + 1));
        check("busy_cycles",  64'(bc),  64'(STEPS));
    endtask

    initial begin : main
        int cyc, bc, pre;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_sum",  {55'd0, ovf, cout, s}, 64'd0);
        rst = 1'b0;

        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'hA5, 8'h5A, 1'b1, 1'b1);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);

        // start held through RUN and DONE with changed operands
        wait_idle();
        x = 8'h30; y = 8'h40; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h30, 8'h40, 1'b0));
        @(posedge clk);
        #1;
        x = 8'h11; y = 8'h22;
        wait_done(cyc, bc);
        check("held_start_latency", 64'(cyc), 64'(STEPS + 1));
        @(negedge clk);
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
        exp_q.push_back(model(8'h11, 8'h22, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bc);
        check("second_op_latency", 64'(cyc), 64'(STEPS + 1));

        // Abort mid-RUN with a nonzero result on the outputs
        wait_idle();
        x = 8'hC3; y = 8'h3D; cin = 1'b1; start = 1'b1;
        exp_q.push_back(model(8'hC3, 8'h3D, 1'b1));
        @(posedge clk);
        #1;
        start = 1'b0;
        pre = (STEPS >= 3) ? 2 : 0;
        repeat (pre) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_sum",  {55'd0, ovf, cout, s}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        do_op(8'h5C, 8'h77, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
